conv_word_sched: RTL
====================

# conv_word_sched

Round-robin scheduler that shares the 32-to-8 byte serializer among several 32-bit word sources.
- Accepts one word at a time from NREQ requesters over a valid/ack handshake.
- Holds each granted word stable on `conv_data` for exactly four `clk_4f` cycles with `conv_valid` high, so the serializer emits bytes 3..0 MSB-first.
- Sits between the per-lane word sources and the serializer, in the 4f clock domain.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters. Legal range 2..7.
- `IDLE_WORD`, default 32'hBCBC_BCBC: fill word. Used only when `IDLE_FILL_EN` is defined.

Ports (name, direction, width, meaning):
- `clk_4f` in 1: the single clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: requester i has a word pending. Held until acked.
- `req_data` in 32*NREQ: word of requester i at bits [32i+31:32i]. Stable while `req_valid[i]` is high.
- `req_ack` out NREQ: one-cycle registered pulse; word i was captured.
- `conv_data` out 32: word presented to the serializer.
- `conv_valid` out 1: drives the serializer's `in`.
- `conv_sel` out 3: index of the source of the current word. 3'b111 means idle fill.
- `byte_idx` out 2: current byte phase. 0 = bits [31:24], 3 = bits [7:0].
- `busy` out 1: high in SEND.

## Operation
- Two states: IDLE and SEND. All outputs are registered.
- **Reset:** state=IDLE, `conv_data`=0, `conv_valid`=0, `conv_sel`=0, `byte_idx`=0, `req_ack`=0, `busy`=0, round-robin pointer `last`=NREQ-1.
- **Arbitration:** search `req_valid` starting at index `last`+1, modulo NREQ. The first set bit is the winner g.
- **Grant (winner exists):** at the edge that performs the grant:
  - `conv_data`←word g, `conv_sel`←g, `conv_valid`←1, `byte_idx`←0, `last`←g, `req_ack[g]`←1, state←SEND.
- **IDLE:** arbitrate every cycle. With no request, all outputs hold their reset values.
- **SEND:** `byte_idx` increments each cycle, from 0 to 3. `req_ack` returns to 0 one cycle after a grant.
- **End of word (SEND with `byte_idx`==3):** arbitrate in the same cycle.
  - Winner: back-to-back grant, no bubble. `conv_valid` stays high.
  - No winner: state←IDLE, `conv_valid`←0, `conv_data`←0.
- **Word integrity:** `conv_data` never changes while `byte_idx`≠3 is being presented. A word is acked exactly once.
- **Serializer alignment:** `conv_valid` rises only with `byte_idx`=0 and stays high in multiples of four cycles. The serializer's byte counter therefore equals `byte_idx` at all times.
- **Reset mid-word:** the in-flight word is abandoned. It was already acked, so it is not re-sent. `last` returns to NREQ-1.
- **Requester dropping `req_valid` before ack:** legal. That requester is simply not selected.

## Timing
- Latency: `req_valid[i]` high in IDLE at cycle n, with i the winner:
  - `req_ack[i]` is high in cycle n+1.
  - `conv_valid`=1 and `byte_idx`=0 in cycle n+1.
  - Byte 3 is presented in cycle n+4.
- A requester samples `req_ack` and may present its next word from cycle n+2. The earliest re-arbitration is cycle n+4, so no stale word can be captured.
- Sustained throughput: one word per 4 cycles, with `conv_valid` continuously high.
- Fairness: with all requesters valid, grants rotate 0,1,…,NREQ-1,0. Worst-case wait is 4·(NREQ-1) cycles after the current word ends.

## Configuration
- `IDLE_FILL_EN` defined:
  - Wherever a grant would find no winner (IDLE, or end of word), load a fill word instead: `conv_data`←IDLE_WORD, `conv_sel`←3'b111, `conv_valid`←1, `byte_idx`←0, no ack, state←SEND, `last` unchanged.
  - The serializer output is therefore continuous from the second cycle after reset release.
- `IDLE_FILL_EN` undefined:
  - `conv_valid` drops to 0 when there is no winner, as described under Operation.
  - `conv_sel` never takes the value 3'b111.

## Test plan
- **Reset:** hold `reset` 3 cycles with all `req_valid`=1 → all outputs 0 and no ack. Release → first grant to requester 0, `req_ack`=4'b0001 one cycle later.
- **Single word:** requester 2 only, word 32'hA1B2C3D4 → `conv_valid` high 4 cycles, `byte_idx` 0,1,2,3, `conv_sel`=2. Serializer bytes A1,B2,C3,D4. Then `conv_valid`=0 (without `IDLE_FILL_EN`).
- **All four valid continuously:** grant order 0,1,2,3,0, with `req_ack` pulses spaced exactly 4 cycles apart. No `conv_valid` gap across 20 cycles.
- **Reset mid-word:** assert `reset` when `byte_idx`=1 → next cycle `conv_valid`=0. After release, requester 0 wins even if requester 1 was served last.
- **Back-to-back from one requester:** requester 1 streams 32'h00000001 then 32'h00000002 → second ack exactly 4 cycles after the first. `conv_data` changes only on the `byte_idx` 3→0 transition.
- **`IDLE_FILL_EN` build:** no requests → `conv_data`=32'hBCBCBCBC, `conv_sel`=7, `conv_valid` continuously 1. A request raised mid-fill is granted at the next `byte_idx`=0.

Source files
------------

// File: rtl/conv_word_sched_if.sv
// Word-source and serializer-side signals of the round-robin word scheduler.
// The master modport is the scheduler side and the slave modport is its environment.
interface conv_word_sched_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ack;
    logic [31:0]        conv_data;
    logic               conv_valid;
    logic [2:0]         conv_sel;
    logic [1:0]         byte_idx;
    logic               busy;

    modport master (
        input  req_valid, req_data,
        output req_ack, conv_data, conv_valid, conv_sel, byte_idx, busy
    );

    modport slave (
        output req_valid, req_data,
        input  req_ack, conv_data, conv_valid, conv_sel, byte_idx, busy
    );
endinterface

// File: rtl/conv_word_sched.sv
// Round-robin scheduler feeding 32-bit words to a 32-to-8 serializer; IDLE_FILL_EN enables idle fill words.
// Latency: request seen in IDLE is acked and presented at byte_idx 0 on the next cycle; one word per 4 cycles.
// Backpressure: none downstream; requesters hold req_valid until a one-cycle req_ack pulse.
module conv_word_sched #(
    parameter int          NREQ      = 4,
    parameter logic [31:0] IDLE_WORD = 32'hBCBC_BCBC
) (
    input  logic          clk_4f,
    input  logic          reset,
    conv_word_sched_if.master bus
);

`ifdef IDLE_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [2:0]      last_q, last_d;
    logic [31:0]     conv_data_q, conv_data_d;
    logic            conv_valid_q, conv_valid_d;
    logic [2:0]      conv_sel_q, conv_sel_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic            busy_q, busy_d;

    logic            found_hi, found_lo, found;
    logic [2:0]      win_hi, win_lo, win;
    logic [31:0]     win_data;
    logic            arb;

    // Round-robin: lowest requester above last wins, else lowest at or below last.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (3'(i) > last_q) begin
                    found_hi = 1'b1;
                    win_hi   = 3'(i);
                end else begin
                    found_lo = 1'b1;
                    win_lo   = 3'(i);
                end
            end
        end
        found = found_hi | found_lo;
        win   = found_hi ? win_hi : win_lo;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == 3'(i)) begin
                win_data = bus.req_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        conv_data_d  = conv_data_q;
        conv_valid_d = conv_valid_q;
        conv_sel_d   = conv_sel_q;
        byte_idx_d   = byte_idx_q;
        req_ack_d    = '0;
        busy_d       = busy_q;

        arb = (state_q == S_IDLE) || (byte_idx_q == 2'd3);

        if (state_q == S_SEND && byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
        end

        if (arb) begin
            if (found) begin
                conv_data_d  = win_data;
                conv_sel_d   = win;
                conv_valid_d = 1'b1;
                byte_idx_d   = 2'd0;
                last_d       = win;
                req_ack_d    = {{(NREQ-1){1'b0}}, 1'b1} << win;
                state_d      = S_SEND;
                busy_d       = 1'b1;
            end else if (FILL_EN) begin
                // Fill keeps the serializer stream continuous without touching fairness.
                conv_data_d  = IDLE_WORD;
                conv_sel_d   = 3'b111;
                conv_valid_d = 1'b1;
                byte_idx_d   = 2'd0;
                state_d      = S_SEND;
                busy_d       = 1'b1;
            end else begin
                conv_data_d  = '0;
                conv_sel_d   = '0;
                conv_valid_d = 1'b0;
                byte_idx_d   = 2'd0;
                state_d      = S_IDLE;
                busy_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_q       <= 3'(NREQ - 1);
            conv_data_q  <= '0;
            conv_valid_q <= 1'b0;
            conv_sel_q   <= '0;
            byte_idx_q   <= '0;
            req_ack_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            conv_data_q  <= conv_data_d;
            conv_valid_q <= conv_valid_d;
            conv_sel_q   <= conv_sel_d;
            byte_idx_q   <= byte_idx_d;
            req_ack_q    <= req_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ack    = req_ack_q;
    assign bus.conv_data  = conv_data_q;
    assign bus.conv_valid = conv_valid_q;
    assign bus.conv_sel   = conv_sel_q;
    assign bus.byte_idx   = byte_idx_q;
    assign bus.busy       = busy_q;

endmodule
